// File: rtl/fc_accumulator_if.sv
// fc_accumulator_if: stream, control and output-buffer signals between
// fc_controller (master) and fc_accumulator (slave).
interface fc_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 7
);
    logic                     start_i;
    logic [PTR_W-1:0]         out_node_num_i;
    logic signed [DATA_W-1:0] ifmap_i;
    logic signed [DATA_W-1:0] weight_i;
    logic                     valid_i;
    logic                     last_i;
    logic                     rst_buf_n_i;
    logic                     obuf_wren_o;
    logic [PTR_W-1:0]         obuf_wrptr_o;
    logic signed [DATA_W-1:0] obuf_wdata_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, out_node_num_i, ifmap_i, weight_i, valid_i, last_i, rst_buf_n_i,
        input  obuf_wren_o, obuf_wrptr_o, obuf_wdata_o, busy_o, done_o
    );

    modport slave (
        input  start_i, out_node_num_i, ifmap_i, weight_i, valid_i, last_i, rst_buf_n_i,
        output obuf_wren_o, obuf_wrptr_o, obuf_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/fc_accumulator.sv
// fc_accumulator: signed MAC per output node followed by requantisation
// (round-half-up arithmetic shift, optional ReLU, int8 saturation). One
// result per node is written to the output buffer; done_o pulses once the
// layer's last node has been written.
// Optional feature: define FC_RELU_EN to clamp negative results to 0.
module fc_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 0,
    parameter int PTR_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    fc_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Rounding constant: half an LSB of the shifted result, or nothing at SHIFT=0.
    localparam int                 RND_SH  = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic signed [ACC_W:0] RND_C = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
    // Saturation bounds of the DATA_W-bit signed output, held at ACC_W+1 bits.
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DATA_W-1:0] OUT_MAX = SAT_MAX[DATA_W-1:0];
    localparam logic signed [DATA_W-1:0] OUT_MIN = ~OUT_MAX;

    // Requantise an accumulator value to the DATA_W-bit output range. One
    // guard bit keeps the rounding addition from overflowing.
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W:0] ext_v;
        logic signed [ACC_W:0] rnd_v;
        logic signed [ACC_W:0] r_v;
        ext_v = {sum[ACC_W-1], sum};
        rnd_v = ext_v + RND_C;
        r_v   = rnd_v >>> SHIFT;
`ifdef FC_RELU_EN
        if (r_v[ACC_W]) begin
            r_v = '0;
        end
`endif
        if (r_v > SAT_MAX) begin
            requant = OUT_MAX;
        end else if (r_v < SAT_MIN) begin
            requant = OUT_MIN;
        end else begin
            requant = r_v[DATA_W-1:0];
        end
    endfunction

    state_t                   state_r;
    logic [PTR_W-1:0]         num_r;
    logic [PTR_W-1:0]         count_r;
    logic                     busy_r;
    logic                     done_r;

    logic signed [2*DATA_W-1:0] p_r;
    logic                     p_valid_r;
    logic                     p_last_r;
    logic signed [ACC_W-1:0]  acc_r;

    logic                     wren_r;
    logic [PTR_W-1:0]         wrptr_r;
    logic signed [DATA_W-1:0] wdata_r;

    logic                     run_s;
    logic                     clr_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [DATA_W-1:0] q_s;
    logic                     write_s;
    logic                     final_s;

    // Stage-2 arithmetic and the write/finish decisions shared by the FSM and datapath.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        clr_s   = run_s && !bus.rst_buf_n_i;
        sum_s   = acc_r + {{(ACC_W-2*DATA_W){p_r[2*DATA_W-1]}}, p_r};
        q_s     = requant(sum_s);
        // The count limit stops any product stream beyond the layer from writing.
        write_s = run_s && bus.rst_buf_n_i && p_valid_r && p_last_r && (count_r < num_r);
        // The last node's write is on the bus and the count has already moved past it.
        final_s = run_s && wren_r && (count_r == num_r);
    end

    // Layer-control FSM: node count, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            num_r   <= {PTR_W{1'b0}};
            count_r <= {PTR_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start_i) begin
                        num_r   <= bus.out_node_num_i;
                        count_r <= {PTR_W{1'b0}};
                        if (bus.out_node_num_i == {PTR_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (final_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (write_s) begin
                        count_r <= count_r + PTR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the signed product with its valid/last tags while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r       <= {(2*DATA_W){1'b0}};
            p_valid_r <= 1'b0;
            p_last_r  <= 1'b0;
        end else if (run_s && bus.rst_buf_n_i) begin
            p_r       <= (2*DATA_W)'(bus.ifmap_i) * (2*DATA_W)'(bus.weight_i);
            p_valid_r <= bus.valid_i;
            p_last_r  <= bus.valid_i && bus.last_i;
        end else begin
            p_valid_r <= 1'b0;
            p_last_r  <= 1'b0;
        end
    end

    // Stage 2: accumulate, and on a node's last product emit the requantised write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {ACC_W{1'b0}};
            wren_r  <= 1'b0;
            wrptr_r <= {PTR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (clr_s) begin
            // Buffer clear drops the partial sum and any write still in flight.
            acc_r  <= {ACC_W{1'b0}};
            wren_r <= 1'b0;
        end else if (run_s && p_valid_r) begin
            if (p_last_r) begin
                acc_r  <= {ACC_W{1'b0}};
                wren_r <= write_s;
                if (write_s) begin
                    wrptr_r <= count_r;
                    wdata_r <= q_s;
                end
            end else begin
                acc_r  <= sum_s;
                wren_r <= 1'b0;
            end
        end else begin
            wren_r <= 1'b0;
            if (!run_s) begin
                acc_r <= {ACC_W{1'b0}};
            end
        end
    end

    assign bus.obuf_wren_o  = wren_r;
    assign bus.obuf_wrptr_o = wrptr_r;
    assign bus.obuf_wdata_o = wdata_r;
    assign bus.busy_o       = busy_r;
    assign bus.done_o       = done_r;

endmodule

// File: tb/tb_fc_accumulator.sv
// tb_fc_accumulator: drives identical stimulus into two accumulators
// (SHIFT=0 and SHIFT=2) and checks every output-buffer write and done pulse
// against a reference model computed with plain integer arithmetic.
module tb_fc_accumulator;

    typedef struct packed {
        int cyc;
        int ptr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [6:0] out_num = 7'd0;
    logic signed [7:0] ifm = 8'sd0;
    logic signed [7:0] wgt = 8'sd0;
    logic valid = 1'b0;
    logic last = 1'b0;
    logic rst_buf_n = 1'b1;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    wr_t act_q[2][$];
    wr_t exp_q[2][$];
    int  act_done[2][$];
    int  exp_done[$];

    int     shifts[2] = '{0, 2};
    bit     m_run = 1'b0;
    int     m_num = 0;
    int     m_node = 0;
    longint m_sum = 0;

    fc_accumulator_if #(.DATA_W(8), .PTR_W(7)) if_a ();
    fc_accumulator_if #(.DATA_W(8), .PTR_W(7)) if_b ();

    assign if_a.start_i = start;          assign if_b.start_i = start;
    assign if_a.out_node_num_i = out_num; assign if_b.out_node_num_i = out_num;
    assign if_a.ifmap_i = ifm;            assign if_b.ifmap_i = ifm;
    assign if_a.weight_i = wgt;           assign if_b.weight_i = wgt;
    assign if_a.valid_i = valid;          assign if_b.valid_i = valid;
    assign if_a.last_i = last;            assign if_b.last_i = last;
    assign if_a.rst_buf_n_i = rst_buf_n;  assign if_b.rst_buf_n_i = rst_buf_n;

    fc_accumulator #(.DATA_W(8), .ACC_W(32), .SHIFT(0), .PTR_W(7)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    fc_accumulator #(.DATA_W(8), .ACC_W(32), .SHIFT(2), .PTR_W(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write and done pulse seen by the output buffer.
    always @(negedge clk) begin
        wr_t w;
        if (if_a.obuf_wren_o) begin
            w.cyc = cyc; w.ptr = int'(if_a.obuf_wrptr_o); w.data = int'(if_a.obuf_wdata_o);
            act_q[0].push_back(w);
        end
        if (if_b.obuf_wren_o) begin
            w.cyc = cyc; w.ptr = int'(if_b.obuf_wrptr_o); w.data = int'(if_b.obuf_wdata_o);
            act_q[1].push_back(w);
        end
        if (if_a.done_o) act_done[0].push_back(cyc);
        if (if_b.done_o) act_done[1].push_back(cyc);
    end

    // Reference requantisation: round half up of sum / 2^sh, ReLU, clamp to int8.
    function automatic int model_q(input longint sum, input int sh);
        longint s, d, r, q;
        s = longint'(int'(sum));
        if (sh > 0) begin
            d = longint'(1) <<< sh;
            r = s + d / 2;
            q = r / d;
            if ((r % d) != 0 && r < 0) q = q - 1;
        end else begin
            q = s;
        end
`ifdef FC_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; out_num = 7'(n); valid = 1'b0; last = 1'b0; rst_buf_n = 1'b1;
        m_run = (n != 0); m_num = n; m_node = 0; m_sum = 0;
        if (n == 0) exp_done.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive one cycle of stream input and update the reference model.
    task automatic send(input int a, input int w, input bit v, input bit l, input bit rb);
        wr_t e;
        bit rolled;
        @(negedge clk);
        start = 1'b0; ifm = 8'(a); wgt = 8'(w); valid = v; last = l; rst_buf_n = rb;
        rolled = 1'b0;
        if (!rb) begin
            // A clear one cycle after a last cancels that node's write.
            for (int d = 0; d < 2; d++) begin
                if (exp_q[d].size() > 0 && exp_q[d][$].cyc == cyc + 1) begin
                    void'(exp_q[d].pop_back());
                    rolled = 1'b1;
                end
            end
            if (rolled) begin
                m_node = m_node - 1; m_run = 1'b1;
                if (exp_done.size() > 0 && exp_done[$] == cyc + 2) void'(exp_done.pop_back());
            end
            m_sum = 0;
        end else if (m_run && v) begin
            m_sum = m_sum + longint'(a * w);
            if (l) begin
                for (int d = 0; d < 2; d++) begin
                    e.cyc = cyc + 2; e.ptr = m_node; e.data = model_q(m_sum, shifts[d]);
                    exp_q[d].push_back(e);
                end
                m_sum = 0; m_node = m_node + 1;
                if (m_node == m_num) begin
                    m_run = 1'b0;
                    exp_done.push_back(cyc + 3);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({if_a.obuf_wren_o, if_a.obuf_wrptr_o, if_a.obuf_wdata_o, if_a.busy_o, if_a.done_o} !== 18'd0) begin
            n_fail++; $display("FAIL reset_a: outputs %h, required 0",
                {if_a.obuf_wren_o, if_a.obuf_wrptr_o, if_a.obuf_wdata_o, if_a.busy_o, if_a.done_o});
        end
        n_cmp++;
        if ({if_b.obuf_wren_o, if_b.obuf_wrptr_o, if_b.obuf_wdata_o, if_b.busy_o, if_b.done_o} !== 18'd0) begin
            n_fail++; $display("FAIL reset_b: outputs %h, required 0",
                {if_b.obuf_wren_o, if_b.obuf_wrptr_o, if_b.obuf_wdata_o, if_b.busy_o, if_b.done_o});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        do_start(3);
        for (int i = 1; i <= 5; i++) send(i, i, 1'b1, i == 5, 1'b1);
        for (int i = 1; i <= 5; i++) send(i, -1, 1'b1, i == 5, 1'b1);
        for (int i = 1; i <= 5; i++) send(127, 127, 1'b1, i == 5, 1'b1);
        idle(5);
        n_cmp++;
        if (act_q[0].size() != 3 || act_q[0][0].data != 55 || act_q[0][2].data != 127) begin
            n_fail++; $display("FAIL basic_plan: %0d writes, node0/2 data mismatch, required 55/127", act_q[0].size());
        end
        n_cmp++;
`ifdef FC_RELU_EN
        if (act_q[0].size() != 3 || act_q[0][1].data != 0) begin
`else
        if (act_q[0].size() != 3 || act_q[0][1].data != -15) begin
`endif
            n_fail++; $display("FAIL basic_node1: node1 data wrong, required -15 (0 with ReLU)");
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != exp_q[d].size()) begin
                n_fail++; $display("FAIL basic_count dut%0d: %0d writes, required %0d", d, act_q[d].size(), exp_q[d].size());
            end else for (int i = 0; i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (act_q[d][i] !== exp_q[d][i]) begin
                    n_fail++; $display("FAIL basic_wr%0d dut%0d: cyc/ptr/data %0d/%0d/%0d, required %0d/%0d/%0d", i, d,
                        act_q[d][i].cyc, act_q[d][i].ptr, act_q[d][i].data, exp_q[d][i].cyc, exp_q[d][i].ptr, exp_q[d][i].data);
                end
            end
            n_cmp++;
            if (act_done[d].size() != 1 || exp_done.size() != 1 || act_done[d][0] != exp_done[0]) begin
                n_fail++; $display("FAIL basic_done dut%0d: %0d pulses, required 1 at cycle %0d", d, act_done[d].size(), exp_done[0]);
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_rounding();
        int req_b[3];
        do_start(3);
        send(2, 3, 1'b1, 1'b1, 1'b1);
        send(3, -2, 1'b1, 1'b1, 1'b1);
        idle(1);
        send(1, 1, 1'b1, 1'b1, 1'b1);
        idle(5);
`ifdef FC_RELU_EN
        req_b = '{2, 0, 0};
`else
        req_b = '{2, -1, 0};
`endif
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act_q[1].size() != 3 || act_q[1][i].data != req_b[i]) begin
                n_fail++; $display("FAIL round_plan%0d: shift-2 data wrong or missing, required %0d", i, req_b[i]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != exp_q[d].size()) begin
                n_fail++; $display("FAIL round_count dut%0d: %0d writes, required %0d", d, act_q[d].size(), exp_q[d].size());
            end else for (int i = 0; i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (act_q[d][i] !== exp_q[d][i]) begin
                    n_fail++; $display("FAIL round_wr%0d dut%0d: cyc/ptr/data %0d/%0d/%0d, required %0d/%0d/%0d", i, d,
                        act_q[d][i].cyc, act_q[d][i].ptr, act_q[d][i].data, exp_q[d][i].cyc, exp_q[d][i].ptr, exp_q[d][i].data);
                end
            end
            n_cmp++;
            if (act_done[d].size() != 1 || act_done[d][0] != exp_done[0]) begin
                n_fail++; $display("FAIL round_done dut%0d: %0d pulses, required 1 at cycle %0d", d, act_done[d].size(), exp_done[0]);
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_clear();
        do_start(1);
        for (int i = 0; i < 3; i++) send(10, 10, 1'b1, 1'b0, 1'b1);
        send(0, 0, 1'b0, 1'b0, 1'b0);
        send(1, 1, 1'b1, 1'b1, 1'b1);
        idle(5);
        n_cmp++;
        if (act_q[0].size() != 1 || act_q[0][0].ptr != 0 || act_q[0][0].data != 1) begin
            n_fail++; $display("FAIL clear_plan: %0d writes, required one write ptr0 data 1", act_q[0].size());
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != 1 || exp_q[d].size() != 1 || act_q[d][0] !== exp_q[d][0]) begin
                n_fail++; $display("FAIL clear_wr dut%0d: %0d writes, required 1 with data %0d", d, act_q[d].size(), exp_q[d][0].data);
            end
            n_cmp++;
            if (act_done[d].size() != 1 || act_done[d][0] != exp_done[0]) begin
                n_fail++; $display("FAIL clear_done dut%0d: %0d pulses, required 1 at cycle %0d", d, act_done[d].size(), exp_done[0]);
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_empty();
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (if_a.busy_o !== 1'b0 || if_b.busy_o !== 1'b0) begin
                n_fail++; $display("FAIL empty_busy%0d: busy %b/%b, required 0", i, if_a.busy_o, if_b.busy_o);
            end
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != 0) begin
                n_fail++; $display("FAIL empty_wr dut%0d: %0d writes, required 0", d, act_q[d].size());
            end
            n_cmp++;
            if (act_done[d].size() != 1 || act_done[d][0] != exp_done[0]) begin
                n_fail++; $display("FAIL empty_done dut%0d: %0d pulses, required 1 at cycle %0d", d, act_done[d].size(), exp_done[0]);
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_async_reset();
        do_start(2);
        send(3, 4, 1'b1, 1'b0, 1'b1);
        send(5, 6, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b0; last = 1'b0;
        exp_q[0].delete(); exp_q[1].delete(); exp_done.delete(); m_run = 1'b0;
        #1;
        n_cmp++;
        if ({if_a.obuf_wren_o, if_a.obuf_wrptr_o, if_a.obuf_wdata_o, if_a.busy_o, if_a.done_o,
             if_b.obuf_wren_o, if_b.obuf_wrptr_o, if_b.obuf_wdata_o, if_b.busy_o, if_b.done_o} !== 36'd0) begin
            n_fail++; $display("FAIL areset_out: outputs not cleared while rst_n low, required all 0");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != 0 || act_done[d].size() != 0) begin
                n_fail++; $display("FAIL areset_nowr dut%0d: %0d writes %0d dones, required 0/0", d, act_q[d].size(), act_done[d].size());
            end
        end
        do_start(1);
        send(7, -3, 1'b1, 1'b1, 1'b1);
        idle(5);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != 1 || exp_q[d].size() != 1 || act_q[d][0] !== exp_q[d][0]) begin
                n_fail++; $display("FAIL areset_restart dut%0d: %0d writes, required 1 at ptr0 data %0d", d, act_q[d].size(), exp_q[d][0].data);
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_extraneous();
        for (int i = 0; i < 3; i++) send(9, 9, 1'b1, 1'b1, 1'b1);
        do_start(2);
        send(4, 4, 1'b1, 1'b1, 1'b1);
        send(-5, 3, 1'b1, 1'b1, 1'b1);
        idle(4);
        for (int i = 0; i < 3; i++) send(9, 9, 1'b1, 1'b1, 1'b1);
        idle(4);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != exp_q[d].size()) begin
                n_fail++; $display("FAIL extra_count dut%0d: %0d writes, required %0d", d, act_q[d].size(), exp_q[d].size());
            end else for (int i = 0; i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (act_q[d][i] !== exp_q[d][i]) begin
                    n_fail++; $display("FAIL extra_wr%0d dut%0d: cyc/ptr/data %0d/%0d/%0d, required %0d/%0d/%0d", i, d,
                        act_q[d][i].cyc, act_q[d][i].ptr, act_q[d][i].data, exp_q[d][i].cyc, exp_q[d][i].ptr, exp_q[d][i].data);
                end
            end
            n_cmp++;
            if (act_done[d].size() != 1 || act_done[d][0] != exp_done[0]) begin
                n_fail++; $display("FAIL extra_done dut%0d: %0d pulses, required 1", d, act_done[d].size());
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    task automatic test_random();
        for (int layer = 0; layer < 4; layer++) begin
            int n;
            n = int'($urandom_range(1, 6));
            do_start(n);
            for (int k = 0; k < n; k++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int j = 0; j < len; j++) begin
                    if ($urandom_range(0, 5) == 0) idle(1);
                    if ($urandom_range(0, 15) == 0) send(0, 0, 1'b0, 1'b0, 1'b0);
                    send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                         1'b1, j == len - 1, 1'b1);
                end
            end
            while (m_run) send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1, 1'b1, 1'b1);
            idle(4);
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_q[d].size() != exp_q[d].size()) begin
                n_fail++; $display("FAIL rand_count dut%0d: %0d writes, required %0d", d, act_q[d].size(), exp_q[d].size());
            end else for (int i = 0; i < exp_q[d].size(); i++) begin
                n_cmp++;
                if (act_q[d][i] !== exp_q[d][i]) begin
                    n_fail++; $display("FAIL rand_wr%0d dut%0d: cyc/ptr/data %0d/%0d/%0d, required %0d/%0d/%0d", i, d,
                        act_q[d][i].cyc, act_q[d][i].ptr, act_q[d][i].data, exp_q[d][i].cyc, exp_q[d][i].ptr, exp_q[d][i].data);
                end
            end
            n_cmp++;
            if (act_done[d].size() != exp_done.size()) begin
                n_fail++; $display("FAIL rand_done_count dut%0d: %0d pulses, required %0d", d, act_done[d].size(), exp_done.size());
            end else for (int i = 0; i < exp_done.size(); i++) begin
                n_cmp++;
                if (act_done[d][i] != exp_done[i]) begin
                    n_fail++; $display("FAIL rand_done%0d dut%0d: cycle %0d, required %0d", i, d, act_done[d][i], exp_done[i]);
                end
            end
            act_q[d].delete(); exp_q[d].delete(); act_done[d].delete();
        end
        exp_done.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_clear();
        test_empty();
        test_async_reset();
        test_extraneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
